// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : data-memory responder for the core's load/store path.
// Rev 1.0 : initial release.
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int ADDR_WORDS = 4096,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int            AW         = $clog2(ADDR_WORDS);
  localparam logic [32:0]   C_LIMIT    = 33'(ADDR_WORDS) * 33'd4;
  localparam logic [3:0]    C_CNT_LAST = 4'(LATENCY - 1);
  localparam logic [AW-1:0] C_PTR_LAST = AW'(ADDR_WORDS - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic          err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rerr_q, rerr_d;

  logic [31:0]   mem [ADDR_WORDS];

  logic [AW-1:0] w_req_idx;
  logic          w_req_err;
  logic          w_accept;
  logic          w_store_we;
  logic          w_init_we;
  logic          w_cur_write;
  logic          w_cur_err;
  logic [AW-1:0] w_cur_idx;
  logic [31:0]   w_rd_word;

  assign w_req_idx  = req_addr[AW+1:2];
  assign w_req_err  = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= C_LIMIT);
  assign w_accept   = (state_q == S_IDLE) && req_valid;
  assign w_store_we = w_accept && req_write && !w_req_err;
  assign w_init_we  = (state_q == S_INIT);

  // With LATENCY=1 RESP is entered on the accepting edge, so the live request
  // must be used instead of the latched copy.
  assign w_cur_write = (state_q == S_IDLE) ? req_write : write_q;
  assign w_cur_err   = (state_q == S_IDLE) ? w_req_err : err_q;
  assign w_cur_idx   = (state_q == S_IDLE) ? w_req_idx : idx_q;
  assign w_rd_word   = mem[w_cur_idx];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    err_d   = err_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;

    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == C_PTR_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          idx_d   = w_req_idx;
          err_d   = w_req_err;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == C_CNT_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          rerr_d  = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Response payload is captured once, on entry to RESP, and then held.
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      rdata_d = (w_cur_write || w_cur_err) ? 32'd0 : w_rd_word;
      rerr_d  = w_cur_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Array has no reset; INIT sweeps it to zero after every reset release.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      mem[ptr_q] <= 32'd0;
    end else if (w_store_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) begin
          mem[w_req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : directed self-checking bench for dmem_responder.
// Rev 1.0 : initial release.
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        r1_req_valid = 1'b0, r1_req_write = 1'b0, r1_rsp_ready = 1'b1;
  logic [31:0] r1_req_addr = 32'd0, r1_req_wdata = 32'd0;
  logic [3:0]  r1_req_be = 4'd0;
  logic        r1_req_ready, r1_rsp_valid, r1_rsp_err, r1_busy;
  logic [31:0] r1_rsp_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WORDS(4096), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.ADDR_WORDS(4096), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_write(r1_req_write),
    .req_addr(r1_req_addr), .req_wdata(r1_req_wdata), .req_be(r1_req_be),
    .rsp_valid(r1_rsp_valid), .rsp_ready(r1_rsp_ready), .rsp_rdata(r1_rsp_rdata),
    .rsp_err(r1_rsp_err), .busy(r1_busy)
  );

  // One full request/response on the LATENCY=2 instance, rsp_ready held high.
  // lat counts clock edges from the accepting edge to the edge that samples rsp_valid.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output int lat,
                     output logic [31:0] rd, output logic e);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata;
    e  = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic txn1(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output int lat,
                      output logic [31:0] rd, output logic e);
    int n;
    @(negedge clk);
    r1_req_valid = 1'b1; r1_req_write = w; r1_req_addr = a; r1_req_wdata = d;
    r1_req_be = be; r1_rsp_ready = 1'b1;
    n = 0;
    while (!r1_req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    r1_req_valid = 1'b0;
    lat = 1;
    while (!r1_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = r1_rsp_rdata;
    e  = r1_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset(input string tag);
    int n;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL %s req_ready in reset: got %b want 0", tag, req_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL %s rsp_valid in reset: got %b want 0", tag, rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 32'd0) $display("FAIL %s rsp_rdata in reset: got %h want 0", tag, rsp_rdata); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL %s rsp_err in reset: got %b want 0", tag, rsp_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL %s busy in reset: got %b want 1", tag, busy); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 5000) begin @(posedge clk); #1; n++; end
    total_cnt++; if (n !== 4096) $display("FAIL %s init cycles: got %0d want 4096", tag, n); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL %s busy after init: got %b want 0", tag, busy); else pass_cnt++;
  endtask

  task automatic test_load_after_init();
    int lat; logic [31:0] rd; logic e;
    txn(1'b0, 32'h0000_0010, 32'd0, 4'h0, lat, rd, e);
    total_cnt++; if (rd !== 32'h0) $display("FAIL init_load rdata: got %h want 00000000", rd); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL init_load err: got %b want 0", e); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL init_load latency: got %0d want 2", lat); else pass_cnt++;
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic e;
    txn(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, lat, rd, e);
    total_cnt++; if (lat !== 2) $display("FAIL store latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL store rdata: got %h want 00000000", rd); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL store err: got %b want 0", e); else pass_cnt++;
    txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, lat, rd, e);
    total_cnt++; if (lat !== 2) $display("FAIL load latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'hDEAD_BEEF) $display("FAIL load rdata: got %h want deadbeef", rd); else pass_cnt++;
  endtask

  task automatic test_byte_enables();
    int lat; logic [31:0] rd; logic e;
    txn(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, lat, rd, e);
    txn(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, lat, rd, e);
    txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, lat, rd, e);
    total_cnt++; if (rd !== 32'h11BB_33DD) $display("FAIL be_merge rdata: got %h want 11bb33dd", rd); else pass_cnt++;
    txn(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, lat, rd, e);
    total_cnt++; if (e !== 1'b0) $display("FAIL be_zero err: got %b want 0", e); else pass_cnt++;
    txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, lat, rd, e);
    total_cnt++; if (rd !== 32'h11BB_33DD) $display("FAIL be_zero rdata: got %h want 11bb33dd", rd); else pass_cnt++;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic e;
    txn(1'b0, 32'h0000_0006, 32'h0, 4'hF, lat, rd, e);
    total_cnt++; if (e !== 1'b1) $display("FAIL misalign err: got %b want 1", e); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL misalign rdata: got %h want 00000000", rd); else pass_cnt++;
    // 0x4000 aliases word 0 in the index bits, so a leaked store would show up there
    txn(1'b1, 32'h0000_4000, 32'h5555_AAAA, 4'hF, lat, rd, e);
    total_cnt++; if (e !== 1'b1) $display("FAIL range_store err: got %b want 1", e); else pass_cnt++;
    txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, lat, rd, e);
    total_cnt++; if (rd !== 32'h0) $display("FAIL range_store word0: got %h want 00000000", rd); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL word0 err: got %b want 0", e); else pass_cnt++;
    txn(1'b1, 32'h0000_3FFC, 32'hCAFE_0001, 4'hF, lat, rd, e);
    txn(1'b0, 32'h0000_3FFC, 32'h0, 4'h0, lat, rd, e);
    total_cnt++; if (rd !== 32'hCAFE_0001) $display("FAIL last_word rdata: got %h want cafe0001", rd); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL last_word err: got %b want 0", e); else pass_cnt++;
    txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, lat, rd, e);
    total_cnt++; if (e !== 1'b1) $display("FAIL high_addr err: got %b want 1", e); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL high_addr rdata: got %h want 00000000", rd); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0008; req_be = 4'h0;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    // keep presenting a second request; it must not be taken while busy
    req_addr = 32'h0000_0020;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp[%0d] rsp_valid: got %b want 1", i, rsp_valid); else pass_cnt++;
      total_cnt++; if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL bp[%0d] rsp_rdata: got %h want deadbeef", i, rsp_rdata); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL bp[%0d] req_ready: got %b want 0", i, req_ready); else pass_cnt++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp handshake rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL bp handshake req_ready: got %b want 1", req_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL bp next accept req_ready: got %b want 0", req_ready); else pass_cnt++;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    total_cnt++; if (n !== 1) $display("FAIL bp next latency: got %0d want 1 more edge", n); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 32'h11BB_33DD) $display("FAIL bp next rdata: got %h want 11bb33dd", rsp_rdata); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; int n; logic [31:0] rd; logic e;
    txn(1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, lat, rd, e);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL midrst rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL midrst busy: got %b want 1", busy); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL midrst after edge rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
    test_reset("midrst");
    txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, lat, rd, e);
    total_cnt++; if (rd !== 32'h0) $display("FAIL midrst word0: got %h want 00000000", rd); else pass_cnt++;
  endtask

  task automatic test_latency1();
    int lat; int n; logic [31:0] rd; logic e;
    n = 0;
    while (!r1_req_ready && n < 5000) begin @(posedge clk); #1; n++; end
    total_cnt++; if (r1_req_ready !== 1'b1) $display("FAIL lat1 ready: got %b want 1", r1_req_ready); else pass_cnt++;
    txn1(1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, lat, rd, e);
    total_cnt++; if (lat !== 1) $display("FAIL lat1 store latency: got %0d want 1", lat); else pass_cnt++;
    txn1(1'b0, 32'h0000_0004, 32'h0, 4'h0, lat, rd, e);
    total_cnt++; if (lat !== 1) $display("FAIL lat1 load latency: got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'hCAFE_F00D) $display("FAIL lat1 rdata: got %h want cafef00d", rd); else pass_cnt++;
    txn1(1'b0, 32'h0000_0005, 32'h0, 4'h0, lat, rd, e);
    total_cnt++; if (e !== 1'b1) $display("FAIL lat1 misalign err: got %b want 1", e); else pass_cnt++;
  endtask

  initial begin
    test_reset("reset");
    test_load_after_init();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_latency1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
